regfile_requester: RTL and testbench

- Initiator that drives the 32x16 delayed-access register file (`register_file`) on behalf of an upstream client.
- Accepts one read/write request at a time on a valid/ready handshake, then pulses the register file's `valid[2:0]`.
- Holds addresses and write data stable for the file's fixed latency, captures `read_1`/`read_2`, and returns them on a valid/ready response channel.
- Sits between the datapath control logic and `register_file`.

---
 rtl/regfile_requester.sv | 166 ++++++++++++++++
 tb/tb_regfile_requester.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_requester.sv
// ----------------------------------------------------------------------------
// regfile_requester
//
// Initiator for the 32x16 delayed-access register file. It accepts one
// read/write request at a time from an upstream client, issues a single
// rf_valid pulse, holds the addresses and write data stable while the file
// completes, captures the read data and returns it on a response channel.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op[2:0]           bit0 read port 1, bit1 read port 2, bit2 write
//   req_raddr1/2, req_waddr, req_wdata   request addresses and write data
//   resp_valid/resp_ready response handshake
//   resp_rdata1/2         read data (0 for ports that were not requested)
//   rf_*                  register file interface
//   busy                  high in any state other than IDLE
//
// Optional feature (macro REGFILE_REQ_PERF_CNT_EN):
//   rd_count / wr_count   saturating counts of issued reads and writes
// ----------------------------------------------------------------------------
module regfile_requester #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_raddr1,
    input  logic [ADDR_W-1:0] req_raddr2,
    input  logic [ADDR_W-1:0] req_waddr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata1,
    output logic [DATA_W-1:0] resp_rdata2,
    output logic [2:0]        rf_valid,
    output logic [ADDR_W-1:0] rf_read_addr_1,
    output logic [ADDR_W-1:0] rf_read_addr_2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_1,
    input  logic [DATA_W-1:0] rf_read_2,
    output logic              busy
`ifdef REGFILE_REQ_PERF_CNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] raddr1_q, raddr2_q, waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              drive_rf;

    assign accept = (state == IDLE) && req_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a variable unassigned (no latch).
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        rf_valid   = 3'b000;
        drive_rf   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) next_state = (req_op == 3'b000) ? RESP : ISSUE;
            end
            ISSUE: begin
                rf_valid   = op_q;
                drive_rf   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                drive_rf = 1'b1;
                if (cnt == '0) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The file samples addresses at completion, so they stay on the bus from
    // ISSUE to the end of WAIT; outside that window the bus is parked at 0.
    assign rf_read_addr_1 = drive_rf ? raddr1_q : '0;
    assign rf_read_addr_2 = drive_rf ? raddr2_q : '0;
    assign rf_write_addr  = drive_rf ? waddr_q  : '0;
    assign rf_write_data  = drive_rf ? wdata_q  : '0;

    // NOTE: holding and response registers are reset so that every output is
    // defined (zero) straight out of reset, not just the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            resp_rdata1 <= '0;
            resp_rdata2 <= '0;
        end else begin
            if (accept) begin
                op_q        <= req_op;
                raddr1_q    <= req_raddr1;
                raddr2_q    <= req_raddr2;
                waddr_q     <= req_waddr;
                wdata_q     <= req_wdata;
                // Cleared so write-only and no-op responses return zeros.
                resp_rdata1 <= '0;
                resp_rdata2 <= '0;
            end
            if (state == ISSUE) begin
                cnt <= (op_q[1:0] != 2'b00) ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
            end else if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    // Unrequested ports (and write-only ops) return 0.
                    resp_rdata1 <= op_q[0] ? rf_read_1 : '0;
                    resp_rdata2 <= op_q[1] ? rf_read_2 : '0;
                end
            end
        end
    end

`ifdef REGFILE_REQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == ISSUE) begin
            if (op_q[1:0] != 2'b00 && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (op_q[2] && wr_count != 16'hFFFF)            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_requester.sv
// ----------------------------------------------------------------------------
// tb_regfile_requester
//
// Directed bench for regfile_requester with a behavioural register file.
// The driver pushes the expected response of each request into a scoreboard
// queue; a monitor on the falling edge pops and compares whenever the DUT
// presents a response, and also watches the rf_valid pulse and address hold.
// ----------------------------------------------------------------------------
module tb_regfile_requester;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [4:0]  req_raddr1 = '0, req_raddr2 = '0, req_waddr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_rdata1, resp_rdata2;
    logic [2:0]  rf_valid;
    logic [4:0]  rf_read_addr_1, rf_read_addr_2, rf_write_addr;
    logic [15:0] rf_write_data;
    logic [15:0] rf_read_1, rf_read_2;
    logic        busy;
`ifdef REGFILE_REQ_PERF_CNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    regfile_requester #(.ADDR_W(5), .DATA_W(16), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2),
        .rf_valid(rf_valid), .rf_read_addr_1(rf_read_addr_1),
        .rf_read_addr_2(rf_read_addr_2), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_1(rf_read_1),
        .rf_read_2(rf_read_2), .busy(busy)
`ifdef REGFILE_REQ_PERF_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural register file: reads are combinational from the array,
    // a write commits on the completion edge (RD_LAT after issue if any read
    // is requested, else WR_LAT), so a combined op reads the pre-write value.
    logic [15:0] mem [32];
    int          rf_cnt = 0;
    logic [2:0]  rf_op = '0;
    assign rf_read_1 = mem[rf_read_addr_1];
    assign rf_read_2 = mem[rf_read_addr_2];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (rf_cnt != 0) begin
            rf_cnt <= rf_cnt - 1;
            if (rf_cnt == 1 && rf_op[2]) mem[rf_write_addr] <= rf_write_data;
        end else if (rf_valid != 3'b000) begin
            rf_op  <= rf_valid;
            rf_cnt <= (rf_valid[1:0] != 2'b00) ? RD_LAT : WR_LAT;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] e1;
        logic [15:0] e2;
        int          lat;  // edges after the accepting edge until resp_valid
        int          acc;
    } exp_t;
    exp_t sb[$];

    logic [2:0]  cur_op = '0;
    logic [4:0]  cur_ra1 = '0, cur_ra2 = '0, cur_wa = '0;
    logic [15:0] cur_wd = '0;

    task automatic send(input logic [2:0] op, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] wa, input logic [15:0] wd,
                        input logic [15:0] e1, input logic [15:0] e2, input int lat);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        cur_op = op; cur_ra1 = a1; cur_ra2 = a2; cur_wa = wa; cur_wd = wd;
        req_valid = 1'b1; req_op = op; req_raddr1 = a1; req_raddr2 = a2;
        req_waddr = wa; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.e1 = e1; e.e2 = e2; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !req_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: response scoreboard, rf_valid pulse width, address hold.
    int   rv_len = 0;
    bit   seen = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_len = 0;
            seen   = 1'b0;
        end else begin
            if (rf_valid != 3'b000) begin
                rv_len++;
                check("rf_valid_op", 32'(rf_valid), 32'(cur_op));
            end else if (rv_len != 0) begin
                check("rf_valid_len", rv_len, 32'd1);
                rv_len = 0;
            end
            if (busy && !resp_valid) begin
                check("hold_raddr1", 32'(rf_read_addr_1), 32'(cur_ra1));
                check("hold_raddr2", 32'(rf_read_addr_2), 32'(cur_ra2));
                check("hold_waddr",  32'(rf_write_addr),  32'(cur_wa));
                check("hold_wdata",  32'(rf_write_data),  32'(cur_wd));
            end
            if (resp_valid) begin
                check("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("resp_rdata1",  32'(resp_rdata1), 32'(cur.e1));
                        check("resp_rdata2",  32'(resp_rdata2), 32'(cur.e2));
                        check("resp_latency", cyc - cur.acc,    cur.lat);
                    end
                    seen = 1'b1;
                end else begin
                    check("stable_rdata1", 32'(resp_rdata1), 32'(cur.e1));
                    check("stable_rdata2", 32'(resp_rdata2), 32'(cur.e2));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rf_valid",   32'(rf_valid),   32'd0);
        check("rst_rdata",      {resp_rdata1, resp_rdata2}, 32'd0);
        check("rst_rf_bus",     {rf_read_addr_1, rf_read_addr_2, rf_write_addr, 17'd0}, 32'd0);
        check("rst_rf_wdata",   32'(rf_write_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: write reg 5; 2: read it back on port 1, reg 0 on port 2.
        send(3'b100, 5'd0, 5'd0, 5'd5, 16'hBEEF, 16'h0000, 16'h0000, 1 + WR_LAT);
        send(3'b011, 5'd5, 5'd0, 5'd0, 16'h0000, 16'hBEEF, 16'h0000, 1 + RD_LAT);
        // No-op right after a read: no file access, response data cleared.
        send(3'b000, 5'd5, 5'd5, 5'd5, 16'h5555, 16'h0000, 16'h0000, 0);
        // 3: combined op reads pre-write value; port 2 unrequested returns 0.
        send(3'b101, 5'd7, 5'd5, 5'd7, 16'h1234, 16'h0000, 16'h0000, 1 + RD_LAT);
        send(3'b001, 5'd7, 5'd5, 5'd0, 16'h0000, 16'h1234, 16'h0000, 1 + RD_LAT);
        send(3'b111, 5'd9, 5'd7, 5'd9, 16'hA5A5, 16'h0000, 16'h1234, 1 + RD_LAT);
        // Back-to-back write then read of the same register.
        send(3'b100, 5'd0, 5'd0, 5'd9, 16'h5A5A, 16'h0000, 16'h0000, 1 + WR_LAT);
        send(3'b010, 5'd0, 5'd9, 5'd0, 16'h0000, 16'h0000, 16'h5A5A, 1 + RD_LAT);
        wait_idle();

        // 4: response back-pressure for 5 cycles.
        resp_ready = 1'b0;
        send(3'b010, 5'd0, 5'd5, 5'd0, 16'h0000, 16'h0000, 16'hBEEF, 1 + RD_LAT);
        begin
            int t = 0;
            while (!resp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("bp_resp_seen", 32'(resp_valid), 32'd1);
        end
        repeat (5) @(negedge clk);
        check("bp_resp_held", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", 32'(req_ready),  32'd1);
        check("bp_idle_resp",  32'(resp_valid), 32'd0);

        // 5: asynchronous reset during WAIT.
        send(3'b001, 5'd7, 5'd0, 5'd0, 16'h0000, 16'h1234, 16'h0000, 1 + RD_LAT);
        @(posedge clk);
        #3;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready",  32'(req_ready),  32'd1);
        check("arst_busy",       32'(busy),       32'd0);
        check("arst_rf_valid",   32'(rf_valid),   32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        sb.delete();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;

`ifdef REGFILE_REQ_PERF_CNT_EN
        check("perf_rd_reset", 32'(rd_count), 32'd0);
        check("perf_wr_reset", 32'(wr_count), 32'd0);
`endif
        // 6: three reads, two writes, one combined and a no-op.
        send(3'b001, 5'd7, 5'd0, 5'd0, 16'h0000, 16'h1234, 16'h0000, 1 + RD_LAT);
        send(3'b010, 5'd0, 5'd5, 5'd0, 16'h0000, 16'h0000, 16'hBEEF, 1 + RD_LAT);
        send(3'b011, 5'd7, 5'd5, 5'd0, 16'h0000, 16'h1234, 16'hBEEF, 1 + RD_LAT);
        send(3'b100, 5'd0, 5'd0, 5'd3, 16'h0F0F, 16'h0000, 16'h0000, 1 + WR_LAT);
        send(3'b100, 5'd0, 5'd0, 5'd4, 16'hF0F0, 16'h0000, 16'h0000, 1 + WR_LAT);
        send(3'b101, 5'd3, 5'd4, 5'd3, 16'h3333, 16'h0F0F, 16'h0000, 1 + RD_LAT);
        send(3'b000, 5'd1, 5'd1, 5'd1, 16'h1111, 16'h0000, 16'h0000, 0);
        wait_idle();
`ifdef REGFILE_REQ_PERF_CNT_EN
        check("perf_rd_count", 32'(rd_count), 32'd4);
        check("perf_wr_count", 32'(wr_count), 32'd3);
`endif
        send(3'b011, 5'd3, 5'd4, 5'd0, 16'h0000, 16'h3333, 16'hF0F0, 1 + RD_LAT);
        wait_idle();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
